dvp_capture_window: RTL and testbench

- Parametrised successor to the fixed OV7670 RGB565 pixel capture path.
- Accepts a generic DVP stream (VSYNC/HREF/data) and supports:
  - 1- or 2-byte pixel mode, selected at run time.
  - Configurable sync polarity.
  - Programmable warm-up frame skip.
  - Run-time crop window and power-of-two decimation.
  - Per-frame line/pixel statistics.
- Sits between the camera pads and the frame buffer writer. clk is driven from camera PCLK at top level.

---
 rtl/dvp_capture_window.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_dvp_capture_window.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_capture_window.sv
// dvp_capture_window
//   Captures pixels from a generic DVP camera stream (vsync/href/data) and
//   emits them as single-cycle strobes after cropping and decimation. It
//   sits between the camera pads and the frame buffer writer, and clk is
//   the camera PCLK.
//
//   Handshake: pixel_valid is a one-cycle strobe with no back-pressure.
//   pixel_data/pixel_x/pixel_y/sof/eol are meaningful only while it is
//   high, and the consumer must accept every strobe.
//
// Ports
//   clk, rst_n          capture clock (rising edge), async active-low reset
//   en                  capture enable
//   two_byte            1: two bytes per pixel, 0: one byte, zero-extended
//   swap_bytes          two-byte mode: first byte goes to the LSBs
//   x_start/x_end       inclusive crop columns (source pixels)
//   y_start/y_end       inclusive crop rows
//   x_dec/y_dec         keep one of every 2^n columns / rows
//   dvp_vsync/href/data raw camera inputs
//   pixel_*             output pixel strobe, data and coordinates
//   sof / eol           first pixel of frame / last pixel of output row
//   frame_active        state machine is in ACTIVE
//   frame_done          pulse at the end of each captured frame
//   frame_cnt           captured frame counter (wraps)
//   last_lines/last_ppl source line count and last-line pixel count of the
//                       most recent captured frame
//   line_err            pulse when a two-byte line ends on an odd byte
//   dbg_state           current state machine state
module dvp_capture_window #(
    parameter int DATA_W           = 8,
    parameter int X_W              = 11,
    parameter int Y_W              = 10,
    parameter int SKIP_FRAMES      = 3,
    parameter int VSYNC_BLANK_HIGH = 1,
    parameter int HREF_ACTIVE_HIGH = 1,
    parameter int CNT_W            = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  two_byte,
    input  logic                  swap_bytes,
    input  logic [X_W-1:0]        x_start,
    input  logic [X_W-1:0]        x_end,
    input  logic [Y_W-1:0]        y_start,
    input  logic [Y_W-1:0]        y_end,
    input  logic [1:0]            x_dec,
    input  logic [1:0]            y_dec,
    input  logic                  dvp_vsync,
    input  logic                  dvp_href,
    input  logic [DATA_W-1:0]     dvp_data,
    output logic                  pixel_valid,
    output logic [2*DATA_W-1:0]   pixel_data,
    output logic [X_W-1:0]        pixel_x,
    output logic [Y_W-1:0]        pixel_y,
    output logic                  sof,
    output logic                  eol,
    output logic                  frame_active,
    output logic                  frame_done,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic [Y_W-1:0]        last_lines,
    output logic [X_W-1:0]        last_ppl,
    output logic                  line_err,
    output logic [2:0]            dbg_state
);

    localparam int SK_W = $clog2(SKIP_FRAMES + 2);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_BLANK = 3'd1,
        WAIT_START = 3'd2,
        SKIP       = 3'd3,
        ACTIVE     = 3'd4
    } state_t;

    state_t state_q, state_d;

    // ---------------- input stage ----------------
    logic              vs_s1, vs_s2, hr_s1, hr_s2;
    logic [DATA_W-1:0] data_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1   <= 1'b0;
            vs_s2   <= 1'b0;
            hr_s1   <= 1'b0;
            hr_s2   <= 1'b0;
            data_s1 <= '0;
        end else begin
            vs_s1   <= dvp_vsync;
            vs_s2   <= vs_s1;
            hr_s1   <= dvp_href;
            hr_s2   <= hr_s1;
            data_s1 <= dvp_data;
        end
    end

    // Normalised syncs: vb = vertical blanking, ha = active line.
    logic vb1, vb2, ha1, ha2;
    assign vb1 = (VSYNC_BLANK_HIGH != 0) ? vs_s1 : !vs_s1;
    assign vb2 = (VSYNC_BLANK_HIGH != 0) ? vs_s2 : !vs_s2;
    assign ha1 = (HREF_ACTIVE_HIGH != 0) ? hr_s1 : !hr_s1;
    assign ha2 = (HREF_ACTIVE_HIGH != 0) ? hr_s2 : !hr_s2;

    logic frame_start, frame_end, line_start, line_end;
    assign frame_start = vb2 && !vb1;
    assign frame_end   = !vb2 && vb1;
    assign line_start  = ha1 && !ha2;
    assign line_end    = !ha1 && ha2;

    // ---------------- state machine ----------------
    logic [SK_W-1:0] skip_cnt;
    logic            skip_more, go_active, go_skip, end_frame;

    assign skip_more = int'(skip_cnt) < SKIP_FRAMES;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        go_active = 1'b0;
        go_skip   = 1'b0;
        end_frame = 1'b0;
        case (state_q)
            IDLE:       if (en) state_d = WAIT_BLANK;
            WAIT_BLANK: if (vb1) state_d = WAIT_START;
            WAIT_START: begin
                if (frame_start) begin
                    if (!en) begin
                        state_d = IDLE;
                    end else if (skip_more) begin
                        state_d = SKIP;
                        go_skip = 1'b1;
                    end else begin
                        state_d   = ACTIVE;
                        go_active = 1'b1;
                    end
                end
            end
            SKIP:       if (frame_end) state_d = WAIT_START;
            ACTIVE: begin
                if (frame_end) begin
                    end_frame = 1'b1;
                    state_d   = en ? WAIT_START : IDLE;
                end
            end
            default:    state_d = IDLE;
        endcase
    end

    assign frame_active = (state_q == ACTIVE);
    assign dbg_state    = state_q;

    // ---------------- frame shadows ----------------
    logic           cfg_two_byte, cfg_swap;
    logic [X_W-1:0] cfg_xs, cfg_xe;
    logic [Y_W-1:0] cfg_ys, cfg_ye;
    logic [1:0]     cfg_xdec, cfg_ydec;

    // ---------------- byte assembly / qualification ----------------
    logic [DATA_W-1:0]   hold_q;
    logic                phase_q, phase_eff, in_line, form, emit, first_byte;
    logic [X_W-1:0]      sx_q, sx_eff, sx_inc, line_ppl, dx, x_step;
    logic [Y_W-1:0]      sy_q, sy_inc, dy, y_step, lines_fin;
    logic [X_W-1:0]      ppl_fin;
    logic [2*DATA_W-1:0] pix_word;
    logic                keep_x, keep_y, eol_next, sof_pend;

    // A line-start cycle already carries the first byte of the line, so the
    // phase and column restart combinationally for that byte.
    assign phase_eff  = line_start ? 1'b0 : phase_q;
    assign sx_eff     = line_start ? '0 : sx_q;
    assign in_line    = (state_q == ACTIVE) && ha1;
    assign first_byte = cfg_two_byte && !phase_eff;
    assign form       = in_line && !first_byte;

    assign pix_word = !cfg_two_byte ? {{DATA_W{1'b0}}, data_s1} :
                      cfg_swap      ? {data_s1, hold_q} :
                                      {hold_q, data_s1};

    assign sx_inc = (&sx_eff) ? sx_eff : sx_eff + 1'b1;
    assign sy_inc = (&sy_q) ? sy_q : sy_q + 1'b1;

    assign x_step = {{(X_W-1){1'b0}}, 1'b1} << cfg_xdec;
    assign y_step = {{(Y_W-1){1'b0}}, 1'b1} << cfg_ydec;
    assign dx     = sx_eff - cfg_xs;
    assign dy     = sy_q - cfg_ys;

    assign keep_x = (sx_eff >= cfg_xs) && (sx_eff <= cfg_xe) &&
                    ((dx & (x_step - 1'b1)) == '0);
    assign keep_y = (sy_q >= cfg_ys) && (sy_q <= cfg_ye) &&
                    ((dy & (y_step - 1'b1)) == '0);
    assign emit   = form && keep_x && keep_y;

    // Last kept column of the row: the next kept one would pass x_end.
    assign eol_next = ({1'b0, sx_eff} + {1'b0, x_step}) > {1'b0, cfg_xe};

    // A line may close on the same cycle vsync rises; fold it into the stats.
    assign lines_fin = (line_end && sx_q != '0) ? sy_inc : sy_q;
    assign ppl_fin   = (line_end && sx_q != '0) ? sx_q : line_ppl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_cnt     <= '0;
            cfg_two_byte <= 1'b0;
            cfg_swap     <= 1'b0;
            cfg_xs       <= '0;
            cfg_xe       <= '0;
            cfg_ys       <= '0;
            cfg_ye       <= '0;
            cfg_xdec     <= '0;
            cfg_ydec     <= '0;
            hold_q       <= '0;
            phase_q      <= 1'b0;
            sx_q         <= '0;
            sy_q         <= '0;
            line_ppl     <= '0;
            sof_pend     <= 1'b0;
            pixel_valid  <= 1'b0;
            pixel_data   <= '0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            sof          <= 1'b0;
            eol          <= 1'b0;
            frame_done   <= 1'b0;
            frame_cnt    <= '0;
            last_lines   <= '0;
            last_ppl     <= '0;
            line_err     <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            sof         <= 1'b0;
            eol         <= 1'b0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;

            // Warm-up skipping happens once per enable.
            if (state_q == IDLE)  skip_cnt <= '0;
            else if (go_skip)     skip_cnt <= skip_cnt + 1'b1;

            if (go_active) begin
                cfg_two_byte <= two_byte;
                cfg_swap     <= swap_bytes;
                cfg_xs       <= x_start;
                cfg_xe       <= x_end;
                cfg_ys       <= y_start;
                cfg_ye       <= y_end;
                cfg_xdec     <= x_dec;
                cfg_ydec     <= y_dec;
                phase_q      <= 1'b0;
                sx_q         <= '0;
                sy_q         <= '0;
                line_ppl     <= '0;
                sof_pend     <= 1'b1;
            end

            if (in_line) begin
                phase_q <= first_byte;
                sx_q    <= form ? sx_inc : sx_eff;
                if (first_byte) hold_q <= data_s1;
                if (emit) begin
                    pixel_valid <= 1'b1;
                    pixel_data  <= pix_word;
                    pixel_x     <= dx >> cfg_xdec;
                    pixel_y     <= dy >> cfg_ydec;
                    eol         <= eol_next;
                    sof         <= sof_pend;
                    sof_pend    <= 1'b0;
                end
            end

            if ((state_q == ACTIVE) && line_end) begin
                if (sx_q != '0) begin
                    sy_q     <= sy_inc;
                    line_ppl <= sx_q;
                end
                // A dangling first byte is dropped and flagged.
                if (cfg_two_byte && phase_q) line_err <= 1'b1;
                sx_q    <= '0;
                phase_q <= 1'b0;
            end

            if (end_frame) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 1'b1;
                last_lines <= lines_fin;
                last_ppl   <= ppl_fin;
            end
        end
    end

endmodule

// File: tb/tb_dvp_capture_window.sv
// Testbench for dvp_capture_window. Two instances run in lock-step: one with
// default sync polarities, one with both polarities inverted and driven with
// inverted syncs; both must produce the same pixel and frame results.
module tb_dvp_capture_window;

    localparam int X_W = 11;
    localparam int Y_W = 10;
    localparam int PW  = 16 + X_W + Y_W + 2;
    localparam int SW  = 16 + Y_W + X_W;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus signals ----------------
    logic           en, two_byte, swap_bytes;
    logic [X_W-1:0] x_start, x_end;
    logic [Y_W-1:0] y_start, y_end;
    logic [1:0]     x_dec, y_dec;
    logic           vsync, href;
    logic [7:0]     data;

    // ---------------- DUT outputs ----------------
    logic           pv_a, sof_a, eol_a, fa_a, fd_a, le_a;
    logic [15:0]    pd_a, fc_a;
    logic [X_W-1:0] px_a, lp_a;
    logic [Y_W-1:0] py_a, ll_a;
    logic [2:0]     st_a;
    logic           pv_b, sof_b, eol_b, fa_b, fd_b, le_b;
    logic [15:0]    pd_b, fc_b;
    logic [X_W-1:0] px_b, lp_b;
    logic [Y_W-1:0] py_b, ll_b;
    logic [2:0]     st_b;

    dvp_capture_window dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .two_byte(two_byte),
        .swap_bytes(swap_bytes), .x_start(x_start), .x_end(x_end),
        .y_start(y_start), .y_end(y_end), .x_dec(x_dec), .y_dec(y_dec),
        .dvp_vsync(vsync), .dvp_href(href), .dvp_data(data),
        .pixel_valid(pv_a), .pixel_data(pd_a), .pixel_x(px_a), .pixel_y(py_a),
        .sof(sof_a), .eol(eol_a), .frame_active(fa_a), .frame_done(fd_a),
        .frame_cnt(fc_a), .last_lines(ll_a), .last_ppl(lp_a),
        .line_err(le_a), .dbg_state(st_a)
    );

    dvp_capture_window #(.VSYNC_BLANK_HIGH(0), .HREF_ACTIVE_HIGH(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .two_byte(two_byte),
        .swap_bytes(swap_bytes), .x_start(x_start), .x_end(x_end),
        .y_start(y_start), .y_end(y_end), .x_dec(x_dec), .y_dec(y_dec),
        .dvp_vsync(~vsync), .dvp_href(~href), .dvp_data(data),
        .pixel_valid(pv_b), .pixel_data(pd_b), .pixel_x(px_b), .pixel_y(py_b),
        .sof(sof_b), .eol(eol_b), .frame_active(fa_b), .frame_done(fd_b),
        .frame_cnt(fc_b), .last_lines(ll_b), .last_ppl(lp_b),
        .line_err(le_b), .dbg_state(st_b)
    );

    // ---------------- scoreboard ----------------
    logic [PW-1:0] exp_q0[$];
    logic [PW-1:0] exp_q1[$];
    logic [SW-1:0] stat_q0[$];
    logic [SW-1:0] stat_q1[$];
    int            n_checks, n_fail;
    int            lerr_a, lerr_b;
    logic [15:0]   exp_fc;

    // frame model state
    bit            m_capture, m_tb2, m_sw, m_first;
    int            m_xs, m_xe, m_ys, m_ye, m_xd, m_yd, m_sx;
    logic [7:0]    m_hold;

    task automatic push_pix(input logic [PW-1:0] v);
        exp_q0.push_back(v);
        exp_q1.push_back(v);
    endtask

    task automatic push_stat(input logic [SW-1:0] v);
        stat_q0.push_back(v);
        stat_q1.push_back(v);
    endtask

    task automatic check_pix(input int d, input logic [PW-1:0] act);
        logic [PW-1:0] e;
        bit            have;
        have = 1'b0;
        e    = '0;
        if (d == 0) begin
            if (exp_q0.size() != 0) begin e = exp_q0.pop_front(); have = 1'b1; end
        end else begin
            if (exp_q1.size() != 0) begin e = exp_q1.pop_front(); have = 1'b1; end
        end
        n_checks++;
        if (!have) begin
            n_fail++;
            $display("FAIL pixel dut%0d: unexpected strobe {data,x,y,sof,eol}=%h, required none", d, act);
        end else if (act !== e) begin
            n_fail++;
            $display("FAIL pixel dut%0d: got {data,x,y,sof,eol}=%h, required %h", d, act, e);
        end
    endtask

    task automatic check_stat(input int d, input logic [SW-1:0] act);
        logic [SW-1:0] e;
        bit            have;
        have = 1'b0;
        e    = '0;
        if (d == 0) begin
            if (stat_q0.size() != 0) begin e = stat_q0.pop_front(); have = 1'b1; end
        end else begin
            if (stat_q1.size() != 0) begin e = stat_q1.pop_front(); have = 1'b1; end
        end
        n_checks++;
        if (!have) begin
            n_fail++;
            $display("FAIL frame_done dut%0d: unexpected pulse {cnt,lines,ppl}=%h, required none", d, act);
        end else if (act !== e) begin
            n_fail++;
            $display("FAIL frame_stats dut%0d: got {cnt,lines,ppl}=%h, required %h", d, act, e);
        end
    endtask

    // monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (pv_a) check_pix(0, {pd_a, px_a, py_a, sof_a, eol_a});
            if (pv_b) check_pix(1, {pd_b, px_b, py_b, sof_b, eol_b});
            if (fd_a) check_stat(0, {fc_a, ll_a, lp_a});
            if (fd_b) check_stat(1, {fc_b, ll_b, lp_b});
            if (le_a) lerr_a++;
            if (le_b) lerr_b++;
        end
    end

    task automatic check_reset_state(input string tag);
        logic [PW+SW+5:0] va, vb;
        va = {pv_a, pd_a, px_a, py_a, sof_a, eol_a, fa_a, fd_a, fc_a, ll_a, lp_a, le_a};
        vb = {pv_b, pd_b, px_b, py_b, sof_b, eol_b, fa_b, fd_b, fc_b, ll_b, lp_b, le_b};
        n_checks++;
        if (va !== '0) begin n_fail++; $display("FAIL %s dut0 outputs: got %h, required 0", tag, va); end
        n_checks++;
        if (vb !== '0) begin n_fail++; $display("FAIL %s dut1 outputs: got %h, required 0", tag, vb); end
        n_checks++;
        if (st_a !== 3'd0) begin n_fail++; $display("FAIL %s dut0 state: got %0d, required 0 (IDLE)", tag, st_a); end
        n_checks++;
        if (st_b !== 3'd0) begin n_fail++; $display("FAIL %s dut1 state: got %0d, required 0 (IDLE)", tag, st_b); end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input bit tb2, input bit sw, input int xs, input int xe,
                           input int ys, input int ye, input int xd, input int yd);
        two_byte   = tb2;
        swap_bytes = sw;
        x_start    = X_W'(xs);
        x_end      = X_W'(xe);
        y_start    = Y_W'(ys);
        y_end      = Y_W'(ye);
        x_dec      = 2'(xd);
        y_dec      = 2'(yd);
    endtask

    // Snapshot of the configuration the DUT latches at frame start.
    task automatic snapshot(input bit capture);
        m_capture = capture;
        m_tb2     = two_byte;
        m_sw      = swap_bytes;
        m_xs      = int'(x_start);
        m_xe      = int'(x_end);
        m_ys      = int'(y_start);
        m_ye      = int'(y_end);
        m_xd      = int'(x_dec);
        m_yd      = int'(y_dec);
        m_first   = 1'b1;
    endtask

    task automatic model_byte(input int k, input int l, input logic [7:0] d);
        logic [15:0] pix;
        int          step_x, step_y, last_kept;
        if (m_tb2 && (k % 2 == 0)) begin
            m_hold = d;
            return;
        end
        pix    = !m_tb2 ? {8'h00, d} : (m_sw ? {d, m_hold} : {m_hold, d});
        step_x = 1 << m_xd;
        step_y = 1 << m_yd;
        if (m_sx >= m_xs && m_sx <= m_xe && l >= m_ys && l <= m_ye &&
            ((m_sx - m_xs) % step_x) == 0 && ((l - m_ys) % step_y) == 0) begin
            last_kept = m_xs + ((m_xe - m_xs) / step_x) * step_x;
            push_pix({pix, X_W'((m_sx - m_xs) / step_x), Y_W'((l - m_ys) / step_y),
                      m_first, (m_sx == last_kept)});
            m_first = 1'b0;
        end
        m_sx++;
    endtask

    task automatic drive_line(input int l, input int nb, inout int b, input bit close);
        m_sx = 0;
        href = 1'b1;
        for (int k = 0; k < nb; k++) begin
            data = 8'(b);
            if (m_capture) model_byte(k, l, 8'(b));
            b++;
            tick();
        end
        if (close) begin
            href = 1'b0;
            data = 8'h00;
            repeat (4) tick();
        end
    endtask

    task automatic send_frame(input int nlines, input int nbytes, input int last_bytes,
                              input bit capture, input bit mid_swap);
        int b;
        b = 0;
        snapshot(capture);
        vsync = 1'b1;
        repeat (6) tick();
        vsync = 1'b0;
        repeat (3) tick();
        for (int l = 0; l < nlines; l++) begin
            if (mid_swap && l == 1) swap_bytes = ~swap_bytes;
            drive_line(l, (l == nlines - 1) ? last_bytes : nbytes, b, 1'b1);
        end
        if (capture) begin
            exp_fc++;
            push_stat({exp_fc, Y_W'(nlines), X_W'(m_tb2 ? last_bytes / 2 : last_bytes)});
        end
        vsync = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int b;
        n_checks = 0;
        n_fail   = 0;
        lerr_a   = 0;
        lerr_b   = 0;
        exp_fc   = '0;
        rst_n    = 1'b0;
        en       = 1'b0;
        vsync    = 1'b1;
        href     = 1'b0;
        data     = 8'h00;
        set_cfg(1, 0, 0, 7, 0, 3, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset_initial");
        rst_n = 1'b1;
        tick();
        en = 1'b1;

        // warm-up frames: nothing may be emitted
        repeat (3) send_frame(4, 16, 16, 1'b0, 1'b0);
        // default 2-byte capture: 32 pixels, eol at x=7
        send_frame(4, 16, 16, 1'b1, 1'b0);
        // crop window x 2..5, y 1..2
        set_cfg(1, 0, 2, 5, 1, 2, 0, 0);
        send_frame(4, 16, 16, 1'b1, 1'b0);
        // decimation by 2 in both directions
        set_cfg(1, 0, 0, 7, 0, 3, 1, 1);
        send_frame(4, 16, 16, 1'b1, 1'b0);
        // odd-length last line: line_err, 7 pixels
        set_cfg(1, 0, 0, 7, 0, 3, 0, 0);
        send_frame(4, 16, 15, 1'b1, 1'b0);
        // swap changed mid-frame: no effect on this frame
        send_frame(4, 16, 16, 1'b1, 1'b1);
        // swap now takes effect
        send_frame(4, 16, 16, 1'b1, 1'b0);
        // one-byte mode
        set_cfg(0, 0, 0, 7, 0, 3, 0, 0);
        send_frame(4, 8, 8, 1'b1, 1'b0);
        // empty window: stats only
        set_cfg(1, 0, 5, 2, 0, 3, 0, 0);
        send_frame(4, 16, 16, 1'b1, 1'b0);

        // reset in the middle of an active line
        set_cfg(1, 0, 0, 7, 0, 3, 0, 0);
        snapshot(1'b1);
        b = 0;
        vsync = 1'b1;
        repeat (6) tick();
        vsync = 1'b0;
        repeat (3) tick();
        drive_line(0, 8, b, 1'b0);
        tick();
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("reset_mid_line");
        href = 1'b0;
        data = 8'h00;
        rst_n = 1'b1;
        tick();

        // drain, bounded
        for (int i = 0; i < 50 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) tick();

        n_checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_fail++;
            $display("FAIL pixel_drain: got %0d/%0d pixels outstanding, required 0", exp_q0.size(), exp_q1.size());
        end
        n_checks++;
        if (stat_q0.size() != 0 || stat_q1.size() != 0) begin
            n_fail++;
            $display("FAIL frame_drain: got %0d/%0d frames outstanding, required 0", stat_q0.size(), stat_q1.size());
        end
        n_checks++;
        if (lerr_a != 1) begin n_fail++; $display("FAIL line_err dut0: got %0d pulses, required 1", lerr_a); end
        n_checks++;
        if (lerr_b != 1) begin n_fail++; $display("FAIL line_err dut1: got %0d pulses, required 1", lerr_b); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
